ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single-port program/data RAM of the 8-bit RISC core between two requesters.
- Requester 1 is the CPU (instruction fetch, LDA/ADD/AND/XOR operand reads, STO writes).
- Requester 2 is the host/debug loader (program download, memory inspect).
- Sits between the core's memory interface and the RAM macro.
- Provides a fixed CPU-preferred priority, host anti-starvation, a host lock for uninterrupted program loading, and full host priority while the core is halted (HLT).

Parameters:
- AW, 5, RAM address width (matches the 5-bit instruction operand field).
- DW, 8, data width.
- HOST_WAIT_MAX, 4, number of consecutive denied host cycles before the host is force-granted; range 1..15.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- cpu_req, cpu_we  input  1 each  CPU access request, write enable.
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_gnt  output  1  CPU access issued this cycle.
- cpu_rvalid  output  1  CPU read data valid.
- cpu_rdata  output  DW  CPU read data.
- host_req, host_we, host_lock  input  1 each  host request, write enable, lock hold.
- host_addr  input  AW  host address.
- host_wdata  input  DW  host write data.
- host_gnt  output  1  host access issued this cycle.
- host_rvalid  output  1  host read data valid.
- host_rdata  output  DW  host read data.
- cpu_halt  input  1  core is in HLT.
- ram_en, ram_we  output  1 each  RAM enable, write enable.
- ram_addr  output  AW  RAM address.
- ram_wdata  output  DW  RAM write data.
- ram_rdata  input  DW  RAM read data; synchronous, valid one cycle after ram_en with ram_we=0.
- locked  output  1  host lock active (registered).
- owner  output  2  last issued access: 00 none, 01 cpu, 10 host (registered).

Behaviour:
- Reset (rst=0, asynchronous), all registered state clears:
  - FSM returns to IDLE; locked=0; owner=00; cpu_rvalid=0 and host_rvalid=0; starve_cnt=0.
  - Any read in flight is dropped and no rvalid is produced for it.
  - Combinational outputs (gnt, ram_*) are forced to 0 while rst=0.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it samples gnt=1 on a rising edge.
  - gnt is combinational in the same cycle. At most one gnt is high per cycle.
  - ram_en=gnt_any. ram_we, ram_addr and ram_wdata are muxed from the winner. When nobody is granted, ram_we=0 and ram_addr/ram_wdata=0.
- Read latency:
  - A granted read in cycle N gives rvalid=1 to the same requester in cycle N+1, with rdata=ram_rdata.
  - rdata is 0 when rvalid=0.
  - Writes never produce rvalid.
  - Back-to-back reads produce back-to-back rvalid pulses.
- FSM states:
  - IDLE: no access issued last cycle. Arbitrate per the rules below.
  - CPU: last access belonged to the CPU. Arbitration is the same as IDLE.
  - HOST: last access belonged to the host. If it was granted with host_lock=1, go to LOCK.
  - LOCK: only the host may be granted; cpu_gnt=0. Stay in LOCK while host_lock=1. When host_lock=0, go to IDLE next cycle; that same cycle is arbitrated normally.
- Arbitration outside LOCK, first match wins:
  1. cpu_halt=1 and host_req: host.
  2. host_req and starve_cnt==HOST_WAIT_MAX: host.
  3. cpu_req: cpu.
  4. host_req: host.
- starve_cnt:
  - Increments when host_req=1 and host_gnt=0; saturates at HOST_WAIT_MAX.
  - Clears when host_gnt=1 or host_req=0.
- Boundary conditions:
  - cpu_halt rising during LOCK: no effect (the host already owns the RAM).
  - host_lock=1 with host_req=0 in LOCK: RAM stays idle and the CPU stays blocked.
  - host_lock asserted without a grant: ignored.
  - cpu_req while cpu_halt=1 and host idle: the CPU is still granted.

Decomposition:
- Shared package holds:
  - State enum: IDLE, CPU, HOST, LOCK.
  - Owner encodings: OWN_NONE, OWN_CPU, OWN_HOST.
  - Default AW/DW constants used by the core.
- One natural sub-module: arb_starve_cnt (saturating counter with clear, width 4).
- FSM, mux and rvalid pipeline stay in ram_arbiter.

Test Plan:
- Reset mid-read: host read of addr 5 granted, rst=0 the next cycle → host_rvalid stays 0; owner=00; locked=0.
- CPU only: cpu read addr 3, RAM[3]=8'hA7 → cpu_gnt in cycle N; cpu_rvalid=1 and cpu_rdata=8'hA7 in N+1. A cpu write (addr 4, 8'h3C) gives ram_we=1 and no rvalid.
- Contention and starvation: cpu_req and host_req held continuously, HOST_WAIT_MAX=4 → cpu_gnt for 4 cycles, host_gnt on the 5th, then cpu again; pattern repeats.
- Halt priority: cpu_halt=1 with both requesting → host_gnt every cycle. cpu_halt=0 → the CPU wins the next cycle.
- Lock burst: host writes addr 0..7 with host_lock=1 while cpu_req=1 → 8 consecutive host_gnt, locked=1, cpu_gnt=0 throughout. After host_lock drops, cpu_gnt arrives within 1 cycle.
- Alternating reads: cpu read addr 1, host read addr 2, cpu read addr 1 in successive cycles → each rvalid is on the correct port one cycle later, with no cross-delivery.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RISC core RAM arbiter.
package ram_arbiter_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CPU  = 2'b01,
        ST_HOST = 2'b10,
        ST_LOCK = 2'b11
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_HOST = 2'b10;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive host cycles denied by the arbiter.
module arb_starve_cnt #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == MAX_V);

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port program/data RAM between the CPU and the host loader.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW            = AW_DEF,
    parameter int DW            = DW_DEF,
    parameter int HOST_WAIT_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          cpu_halt,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          locked,
    output logic [1:0]    owner
);

    arb_state_t state_q, state_d;
    logic       locked_q, locked_d;
    logic [1:0] owner_q, owner_d;
    logic       cpu_rv_q, cpu_rv_d;
    logic       host_rv_q, host_rv_d;
    logic       cpu_win, host_win;
    logic       starve_sat;

    arb_starve_cnt #(
        .W   (4),
        .MAX (HOST_WAIT_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (host_req & ~host_gnt),
        .clr (host_gnt | ~host_req),
        .sat (starve_sat)
    );

    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (state_q == ST_LOCK && host_lock) begin
            host_win = host_req;
        end else if (cpu_halt && host_req) begin
            host_win = 1'b1;
        end else if (host_req && starve_sat) begin
            host_win = 1'b1;
        end else if (cpu_req) begin
            cpu_win = 1'b1;
        end else if (host_req) begin
            host_win = 1'b1;
        end
    end

    // Grants are gated so nothing reaches the RAM while reset is held.
    assign cpu_gnt  = cpu_win & rst;
    assign host_gnt = host_win & rst;

    always_comb begin
        ram_en    = cpu_gnt | host_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (host_gnt) begin
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        if (host_gnt) begin
            owner_d = OWN_HOST;
        end else if (cpu_gnt) begin
            owner_d = OWN_CPU;
        end
        if (state_q == ST_LOCK && host_lock) begin
            state_d = ST_LOCK;
        end else if (host_gnt) begin
            state_d = host_lock ? ST_LOCK : ST_HOST;
        end else if (cpu_gnt) begin
            state_d = ST_CPU;
        end
        locked_d  = (state_d == ST_LOCK);
        cpu_rv_d  = cpu_gnt & ~cpu_we;
        host_rv_d = host_gnt & ~host_we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            locked_q  <= 1'b0;
            owner_q   <= OWN_NONE;
            cpu_rv_q  <= 1'b0;
            host_rv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            locked_q  <= locked_d;
            owner_q   <= owner_d;
            cpu_rv_q  <= cpu_rv_d;
            host_rv_q <= host_rv_d;
        end
    end

    assign locked      = locked_q;
    assign owner       = owner_q;
    assign cpu_rvalid  = cpu_rv_q;
    assign host_rvalid = host_rv_q;
    assign cpu_rdata   = cpu_rv_q ? ram_rdata : '0;
    assign host_rdata  = host_rv_q ? ram_rdata : '0;

endmodule
